// File: rtl/adder_arbiter.sv
// Two-requester arbiter in front of one shared, handshaked adder; all outputs registered.
// Define ADDER_ARB_RR_EN for round-robin on contention; the default build gives R0 fixed priority.
module adder_arbiter #(
  parameter int W = 25
) (
  input  logic         CLK,
  input  logic         RSTK,
  input  logic         R0_valid,
  input  logic         R1_valid,
  input  logic [W-1:0] R0_datain1,
  input  logic [W-1:0] R0_datain2,
  input  logic [W-1:0] R1_datain1,
  input  logic [W-1:0] R1_datain2,
  output logic         R0_ack,
  output logic         R1_ack,
  output logic [W-1:0] R_dataout,
  output logic         R_carryout,
  output logic         ADD_valid,
  output logic [W-1:0] ADD_datain1,
  output logic [W-1:0] ADD_datain2,
  input  logic [W-1:0] ADD_dataout,
  input  logic         ADD_carryout,
  input  logic         ADD_ack,
  output logic [1:0]   grant,
  output logic         busy
);

  typedef enum logic [1:0] {
    ARB_IDLE    = 2'd0,
    ARB_ISSUE   = 2'd1,
    ARB_RESP    = 2'd2,
    ARB_RELEASE = 2'd3
  } arb_state_e;

  arb_state_e   state_r;
  arb_state_e   state_nxt_s;
  logic         pick_r1_s;
  logic         granted_valid_s;
  logic [1:0]   grant_nxt_s;
  logic         busy_nxt_s;
  logic         r0_ack_nxt_s;
  logic         r1_ack_nxt_s;
  logic         add_valid_nxt_s;
  logic [W-1:0] add_d1_nxt_s;
  logic [W-1:0] add_d2_nxt_s;
  logic [W-1:0] r_data_nxt_s;
  logic         r_carry_nxt_s;

`ifdef ADDER_ARB_RR_EN
  // last_grant_r = 1 names R1 as the most recent owner
  logic         last_grant_r;
  logic         last_grant_nxt_s;
`endif

  // Winner selection for the IDLE sample
  always_comb begin
    if (R0_valid && R1_valid) begin
`ifdef ADDER_ARB_RR_EN
      pick_r1_s = ~last_grant_r;
`else
      pick_r1_s = 1'b0;
`endif
    end else begin
      pick_r1_s = R1_valid;
    end
  end

  assign granted_valid_s = (grant[0] & R0_valid) | (grant[1] & R1_valid);

  // Next-state and next-output logic
  always_comb begin
    state_nxt_s     = state_r;
    grant_nxt_s     = grant;
    r0_ack_nxt_s    = 1'b0;
    r1_ack_nxt_s    = 1'b0;
    add_valid_nxt_s = 1'b0;
    add_d1_nxt_s    = {W{1'b0}};
    add_d2_nxt_s    = {W{1'b0}};
    r_data_nxt_s    = R_dataout;
    r_carry_nxt_s   = R_carryout;
`ifdef ADDER_ARB_RR_EN
    last_grant_nxt_s = last_grant_r;
`endif
    case (state_r)
      ARB_IDLE: begin
        if (R0_valid || R1_valid) begin
          state_nxt_s     = ARB_ISSUE;
          grant_nxt_s     = pick_r1_s ? 2'b10 : 2'b01;
          add_valid_nxt_s = 1'b1;
          add_d1_nxt_s    = pick_r1_s ? R1_datain1 : R0_datain1;
          add_d2_nxt_s    = pick_r1_s ? R1_datain2 : R0_datain2;
        end else begin
          grant_nxt_s = 2'b00;
        end
      end
      ARB_ISSUE: begin
        if (ADD_ack) begin
          state_nxt_s   = ARB_RESP;
          r_data_nxt_s  = ADD_dataout;
          r_carry_nxt_s = ADD_carryout;
          r0_ack_nxt_s  = grant[0];
          r1_ack_nxt_s  = grant[1];
        end else begin
          // operands stay latched in the output registers until the adder answers
          add_valid_nxt_s = 1'b1;
          add_d1_nxt_s    = ADD_datain1;
          add_d2_nxt_s    = ADD_datain2;
        end
      end
      ARB_RESP: begin
        state_nxt_s = ARB_RELEASE;
      end
      ARB_RELEASE: begin
        if (!granted_valid_s && !ADD_ack) begin
          state_nxt_s = ARB_IDLE;
          grant_nxt_s = 2'b00;
`ifdef ADDER_ARB_RR_EN
          last_grant_nxt_s = grant[1];
`endif
        end else begin
          state_nxt_s = ARB_RELEASE;
        end
      end
      default: begin
        state_nxt_s = ARB_IDLE;
        grant_nxt_s = 2'b00;
      end
    endcase
    busy_nxt_s = (state_nxt_s != ARB_IDLE);
  end

  // State register and registered outputs
  always_ff @(posedge CLK or posedge RSTK) begin
    if (RSTK) begin
      state_r     <= ARB_IDLE;
      grant       <= 2'b00;
      busy        <= 1'b0;
      R0_ack      <= 1'b0;
      R1_ack      <= 1'b0;
      ADD_valid   <= 1'b0;
      ADD_datain1 <= {W{1'b0}};
      ADD_datain2 <= {W{1'b0}};
      R_dataout   <= {W{1'b0}};
      R_carryout  <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      grant       <= grant_nxt_s;
      busy        <= busy_nxt_s;
      R0_ack      <= r0_ack_nxt_s;
      R1_ack      <= r1_ack_nxt_s;
      ADD_valid   <= add_valid_nxt_s;
      ADD_datain1 <= add_d1_nxt_s;
      ADD_datain2 <= add_d2_nxt_s;
      R_dataout   <= r_data_nxt_s;
      R_carryout  <= r_carry_nxt_s;
    end
  end

`ifdef ADDER_ARB_RR_EN
  // Round-robin history; reset names R1 so R0 wins the first contention
  always_ff @(posedge CLK or posedge RSTK) begin
    if (RSTK) begin
      last_grant_r <= 1'b1;
    end else begin
      last_grant_r <= last_grant_nxt_s;
    end
  end
`endif

endmodule

// File: tb/tb_adder_arbiter.sv
// Self-checking bench for adder_arbiter: directed and randomized transactions against a
// behavioural model of arbitration order, latency and pass-through results.
module tb_adder_arbiter;
  localparam int W = 25;
`ifdef ADDER_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rstk;
  logic         r0_valid, r1_valid;
  logic [W-1:0] r0_a, r0_b, r1_a, r1_b;
  logic         R0_ack, R1_ack, R_carryout, ADD_valid, busy;
  logic [W-1:0] R_dataout, ADD_datain1, ADD_datain2;
  logic [1:0]   grant;
  logic [W-1:0] add_dout;
  logic         add_cout, add_ack;

  int checks = 0;
  int errors = 0;
  int adder_k = 1;
  int add_cnt = 0;
  int r0_acks = 0, r1_acks = 0, add_txns = 0;
  int last_owner = 1;

  adder_arbiter #(.W(W)) dut (
    .CLK(clk), .RSTK(rstk),
    .R0_valid(r0_valid), .R1_valid(r1_valid),
    .R0_datain1(r0_a), .R0_datain2(r0_b), .R1_datain1(r1_a), .R1_datain2(r1_b),
    .R0_ack(R0_ack), .R1_ack(R1_ack), .R_dataout(R_dataout), .R_carryout(R_carryout),
    .ADD_valid(ADD_valid), .ADD_datain1(ADD_datain1), .ADD_datain2(ADD_datain2),
    .ADD_dataout(add_dout), .ADD_carryout(add_cout), .ADD_ack(add_ack),
    .grant(grant), .busy(busy)
  );

  always #5 clk = ~clk;

  // Behavioural adder: acks after ADD_valid has been high for adder_k cycles
  always @(posedge clk or posedge rstk) begin
    if (rstk) begin
      add_ack  <= 1'b0;
      add_cnt  <= 0;
      add_dout <= {W{1'b0}};
      add_cout <= 1'b0;
    end else if (add_ack) begin
      add_ack <= 1'b0;
      add_cnt <= 0;
    end else if (ADD_valid) begin
      if (add_cnt + 1 >= adder_k) begin
        add_ack <= 1'b1;
        add_cnt <= 0;
        {add_cout, add_dout} <= {1'b0, ADD_datain1} + {1'b0, ADD_datain2};
      end else begin
        add_cnt <= add_cnt + 1;
      end
    end else begin
      add_cnt <= 0;
    end
  end

  // Event counters for acks and completed adder handshakes
  always @(posedge clk) begin
    if (R0_ack) r0_acks <= r0_acks + 1;
    if (R1_ack) r1_acks <= r1_acks + 1;
    if (ADD_valid && add_ack) add_txns <= add_txns + 1;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_grant"}, 64'(grant), 64'd0);
    check({tag, "_busy"}, 64'(busy), 64'd0);
    check({tag, "_acks"}, 64'({R0_ack, R1_ack}), 64'd0);
    check({tag, "_add_valid"}, 64'(ADD_valid), 64'd0);
    check({tag, "_add_in"}, 64'({ADD_datain1, ADD_datain2}), 64'd0);
    check({tag, "_result"}, 64'({R_carryout, R_dataout}), 64'd0);
  endtask

  // One served request, starting from IDLE with the caller's valids already applied.
  task automatic transact(input int k, input int h, input bit scr);
    int w, lat, r0b, r1b, txb;
    bit seen;
    logic [W-1:0] ea, eb;
    logic [W:0] exp_sum;
    adder_k = k;
    if (r0_valid && r1_valid) w = (RR && last_owner == 0) ? 1 : 0;
    else w = r1_valid ? 1 : 0;
    ea = (w == 1) ? r1_a : r0_a;
    eb = (w == 1) ? r1_b : r0_b;
    exp_sum = {1'b0, ea} + {1'b0, eb};
    r0b = r0_acks; r1b = r1_acks; txb = add_txns;
    lat = 0;
    seen = 1'b0;
    while (!seen && lat < 40) begin
      tick();
      lat++;
      if (lat == 1) begin
        check("issue_valid", 64'(ADD_valid), 64'd1);
        check("issue_in1", 64'(ADD_datain1), 64'(ea));
        check("issue_in2", 64'(ADD_datain2), 64'(eb));
        check("issue_grant", 64'(grant), (w == 1) ? 64'd2 : 64'd1);
        check("issue_busy", 64'(busy), 64'd1);
        if (scr) begin
          r0_a = W'($urandom); r0_b = W'($urandom);
          r1_a = W'($urandom); r1_b = W'($urandom);
        end
      end
      seen = (w == 1) ? R1_ack : R0_ack;
    end
    check("latency", 64'(lat), 64'(k + 2));
    check("result", 64'(R_dataout), 64'(exp_sum[W-1:0]));
    check("carry", 64'(R_carryout), 64'(exp_sum[W]));
    check("resp_add_idle", 64'({ADD_valid, ADD_datain1, ADD_datain2}), 64'd0);
    for (int i = 0; i < h; i++) begin
      tick();
      check("hold_busy", 64'(busy), 64'd1);
      check("hold_no_ack", 64'({R0_ack, R1_ack}), 64'd0);
    end
    if (w == 1) r1_valid = 1'b0;
    else r0_valid = 1'b0;
    for (int i = 0; i < 10 && busy; i++) tick();
    check("release_idle", 64'(busy), 64'd0);
    check("release_grant", 64'(grant), 64'd0);
    check("r0_ack_count", 64'(r0_acks - r0b), (w == 0) ? 64'd1 : 64'd0);
    check("r1_ack_count", 64'(r1_acks - r1b), (w == 1) ? 64'd1 : 64'd0);
    check("adder_txn_count", 64'(add_txns - txb), 64'd1);
    last_owner = w;
  endtask

  initial begin
    int r0b, r1b, txb;
    rstk = 1'b1;
    r0_valid = 1'b0; r1_valid = 1'b0;
    r0_a = {W{1'b0}}; r0_b = {W{1'b0}}; r1_a = {W{1'b0}}; r1_b = {W{1'b0}};
    tick(); tick();
    check_all_zero("reset");
    rstk = 1'b0;
    last_owner = 1;

    // R0 only, small operands, single-cycle adder
    r0_a = 25'h000000A; r0_b = 25'h0000005; r0_valid = 1'b1;
    transact(1, 0, 1'b0);

    // Carry-out boundary, then result must hold while idle
    r0_a = 25'h1FFFFFF; r0_b = 25'h0000001; r0_valid = 1'b1;
    transact(2, 0, 1'b0);
    tick(); tick(); tick();
    check("hold_result", 64'({R_carryout, R_dataout}), 64'h2000000);

    // R1 holds valid one cycle past its ack
    r1_a = W'($urandom); r1_b = W'($urandom); r1_valid = 1'b1;
    transact(1, 1, 1'b0);

    // Operands scrambled while the adder is busy
    r0_a = W'($urandom); r0_b = W'($urandom); r0_valid = 1'b1;
    transact(3, 0, 1'b1);

    // Contention with both requesters re-asserting after every service
    r0_a = W'($urandom); r0_b = W'($urandom); r1_a = W'($urandom); r1_b = W'($urandom);
    r0_valid = 1'b1; r1_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      transact(1 + int'($urandom_range(2)), 0, 1'b0);
      r0_a = W'($urandom); r1_a = W'($urandom);
      r0_valid = 1'b1; r1_valid = 1'b1;
    end
    r0_valid = 1'b0;
    if (r1_valid) transact(1, 0, 1'b0);

    // Randomized single-requester traffic
    for (int i = 0; i < 6; i++) begin
      r0_a = W'($urandom); r0_b = W'($urandom); r1_a = W'($urandom); r1_b = W'($urandom);
      if ($urandom_range(1) == 1) r1_valid = 1'b1;
      else r0_valid = 1'b1;
      transact(1 + int'($urandom_range(3)), int'($urandom_range(2)), 1'($urandom_range(1)));
    end

    // Reset while ARB_ISSUE waits on the adder
    r0_a = W'($urandom); r0_b = W'($urandom); r0_valid = 1'b1;
    adder_k = 2;
    tick();
    check("pre_reset_issue", 64'(ADD_valid), 64'd1);
    r0b = r0_acks; r1b = r1_acks; txb = add_txns;
    rstk = 1'b1;
    #1;
    check_all_zero("midop_reset");
    r0_valid = 1'b0;
    tick(); tick();
    rstk = 1'b0;
    last_owner = 1;
    tick(); tick();
    check("reset_no_ack", 64'((r0_acks - r0b) + (r1_acks - r1b)), 64'd0);
    check("reset_no_txn", 64'(add_txns - txb), 64'd0);
    check("post_reset_idle", 64'({busy, grant}), 64'd0);
    r0_a = W'($urandom); r0_b = W'($urandom); r0_valid = 1'b1;
    transact(1, 0, 1'b0);

    // First contention after reset goes to R0 in either build
    r0_a = W'($urandom); r1_a = W'($urandom);
    r0_valid = 1'b1; r1_valid = 1'b1;
    last_owner = 1;
    rstk = 1'b1;
    #1;
    rstk = 1'b0;
    transact(1, 0, 1'b0);
    check("first_contention_owner", 64'(last_owner), 64'd0);
    transact(1, 0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/adder_arbiter.md
ADDER_ARBITER -- requirements
Module: adder_arbiter

Interface
REQ-001 Parameter W, default 25, the operand/result width of the shared adder.
REQ-002 CLK  input  1  the single clock; all state changes on its rising edge.
REQ-003 RSTK  input  1  asynchronous, active-high reset.
REQ-004 R0_valid, R1_valid  input  1 each  add request from requester 0 and requester 1.
REQ-005 R0_datain1, R0_datain2, R1_datain1, R1_datain2  input  W each  requester operands.
REQ-006 R0_ack, R1_ack  output  1 each  result-ready pulse to requester 0 and requester 1.
REQ-007 R_dataout  output  W  shared result bus; R_carryout  output  1  shared carry.
REQ-008 ADD_valid  output  1; ADD_datain1, ADD_datain2  output  W each  drive the adder.
REQ-009 ADD_dataout  input  W; ADD_carryout  input  1; ADD_ack  input  1  adder response.
REQ-010 grant  output  2  one-hot owner (bit0 = R0, bit1 = R1), 2'b00 when idle; busy  output  1  high in any state other than ARB_IDLE.

Function
REQ-011 The block SHALL have four states, ARB_IDLE, ARB_ISSUE, ARB_RESP and ARB_RELEASE, and all outputs SHALL be registered.
REQ-012 ARB_IDLE: if any Rx_valid is 1, the block SHALL select a winner (REQ-019/020), latch the winner's operands, set grant, and go to ARB_ISSUE; otherwise it SHALL stay in ARB_IDLE.
REQ-013 ARB_ISSUE: ADD_valid SHALL be 1 with the latched operands on ADD_datain1/2, starting the cycle after the request is sampled.
REQ-014 ARB_ISSUE on ADD_ack = 1: the block SHALL capture ADD_dataout/ADD_carryout into R_dataout/R_carryout, drop ADD_valid on the next cycle, and go to ARB_RESP.
REQ-015 ARB_RESP: the granted Rx_ack SHALL be 1 for exactly one cycle; the other ack SHALL stay 0; the next state SHALL be ARB_RELEASE.
REQ-016 ARB_RELEASE: the block SHALL stay until the granted Rx_valid = 0 and ADD_ack = 0, then clear grant, update last_grant, and return to ARB_IDLE.
REQ-017 A request still held the cycle after its ack (registered valid drop) SHALL NOT be re-served.
REQ-018 R_dataout/R_carryout SHALL hold their value until the next capture; ADD_datain1/2 SHALL be 0 outside ARB_ISSUE.
REQ-019 Single request: the requester SHALL be granted regardless of last_grant.
REQ-020 Simultaneous requests: the winner is set by the configuration in REQ-027/028.
REQ-021 Operand changes on the granted Rx_datain after the latch SHALL have no effect on the operation in flight.
REQ-022 Minimum latency from Rx_valid rising (sampled in ARB_IDLE) to Rx_ack SHALL be k+2 cycles, where k is the adder's valid-to-ack delay in cycles (k >= 1).
REQ-023 Addition SHALL be the adder's responsibility; the block SHALL pass operands and results unmodified at width W.

Reset
REQ-024 Asserting RSTK at any time, including mid-operation, SHALL immediately force state ARB_IDLE, grant = 0, busy = 0, R0_ack = R1_ack = 0, ADD_valid = 0, ADD_datain1/2 = 0, R_dataout = 0, R_carryout = 0.
REQ-025 Reset SHALL set last_grant to R1, so that R0 wins the first contention.
REQ-026 After RSTK deasserts, the first request SHALL be sampled on the first rising edge of CLK.

Configuration
REQ-027 With ADDER_ARB_RR_EN defined, simultaneous requests SHALL be granted round-robin to the requester not named in last_grant.
REQ-028 Without ADDER_ARB_RR_EN, simultaneous requests SHALL always be granted to R0 (fixed priority), and last_grant SHALL be unused.

Verification
REQ-029 Apply R0 only, 00000A + 000005, adder k = 1 -> ADD_valid 1 cycle after the request is sampled, R0_ack pulses once with R_dataout = 00000F, R_carryout = 0, R1_ack stays 0.
REQ-030 Apply R0 and R1 together, both held, with RR_EN defined -> grant order R0, R1, R0, ...; without RR_EN -> R0 served every time while R1 starves until R0 drops.
REQ-031 Keep R1_valid high for 1 cycle after R1_ack -> exactly one adder transaction and one ack; the arbiter stays in ARB_RELEASE until the drop.
REQ-032 Apply 1FFFFFF + 0000001 -> R_dataout = 0000000, R_carryout = 1, held stable until the next capture.
REQ-033 Assert RSTK during ARB_ISSUE with an adder ack pending -> all outputs 0 in the same cycle, no Rx_ack, and the next R0 request completes normally.
REQ-034 Change R0 operands during ARB_ISSUE -> ADD_datain1/2 and the result reflect the latched operands only.
